// File: rtl/store_check_pkg.sv
// Shared types and constants for the store check monitor.
package store_check_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_t;

  localparam int unsigned IGN_CNT_W = 16;

endpackage

// File: rtl/store_check_monitor_if.sv
// Store snoop, table configuration, control and status bundle of the monitor.
interface store_check_monitor_if
  import store_check_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned TIMEOUT_W = 16
);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                 MemWrite;
  logic [ADDR_W-1:0]    DataAdr;
  logic [DATA_W-1:0]    WriteData;
  logic                 cfg_we;
  logic [IDX_W-1:0]     cfg_idx;
  logic [ADDR_W-1:0]    cfg_addr;
  logic [DATA_W-1:0]    cfg_data;
  logic [IDX_W:0]       num_checks;
  logic                 ign_en;
  logic [ADDR_W-1:0]    ign_addr;
  logic [TIMEOUT_W-1:0] timeout;
  logic                 start;
  logic                 busy;
  logic                 pass;
  logic                 fail;
  logic                 fail_timeout;
  logic [IDX_W-1:0]     fail_idx;
  logic [ADDR_W-1:0]    bad_addr;
  logic [DATA_W-1:0]    bad_data;
  logic [IDX_W:0]       match_cnt;
  logic [IGN_CNT_W-1:0] ign_cnt;

  modport master (
    output MemWrite, DataAdr, WriteData, cfg_we, cfg_idx, cfg_addr, cfg_data,
           num_checks, ign_en, ign_addr, timeout, start,
    input  busy, pass, fail, fail_timeout, fail_idx, bad_addr, bad_data,
           match_cnt, ign_cnt
  );

  modport slave (
    input  MemWrite, DataAdr, WriteData, cfg_we, cfg_idx, cfg_addr, cfg_data,
           num_checks, ign_en, ign_addr, timeout, start,
    output busy, pass, fail, fail_timeout, fail_idx, bad_addr, bad_data,
           match_cnt, ign_cnt
  );

endinterface

// File: rtl/store_check_monitor_check_table.sv
// Expected (address, data) table: one synchronous write port, one combinational read port.
module check_table #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned IDX_W  = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];

  // Contents deliberately survive reset so a table can be reused across runs.
  always_ff @(posedge clk) begin
    if (we && (32'(widx) < DEPTH)) begin
      mem_addr[widx] <= waddr;
      mem_data[widx] <= wdata;
    end
  end

  always_comb begin
    raddr = '0;
    rdata = '0;
    if (32'(ridx) < DEPTH) begin
      raddr = mem_addr[ridx];
      rdata = mem_data[ridx];
    end
  end

endmodule

// File: rtl/store_check_monitor.sv
// In-order store checker for the core's data-memory port with ignore address and timeout.
module store_check_monitor
  import store_check_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned TIMEOUT_W = 16
) (
  input logic clk,
  input logic reset,
  store_check_monitor_if.slave bus
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W:0]       DEPTH_V = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0]       ONE_M   = (IDX_W+1)'(1);
  localparam logic [TIMEOUT_W-1:0] ONE_T   = TIMEOUT_W'(1);
  localparam logic [IGN_CNT_W-1:0] ONE_I   = IGN_CNT_W'(1);

  state_t               state;
  logic [IDX_W:0]       num_q;
  logic                 ign_en_q;
  logic [ADDR_W-1:0]    ign_addr_q;
  logic [TIMEOUT_W-1:0] timeout_q;
  logic [TIMEOUT_W-1:0] cyc_cnt;

  logic [IDX_W-1:0]     ptr_c;
  logic [ADDR_W-1:0]    exp_addr_c;
  logic [DATA_W-1:0]    exp_data_c;
  logic                 hit_c;
  logic                 ign_c;
  logic                 num_ok_c;
  logic [TIMEOUT_W-1:0] cyc_nxt_c;
  logic                 tmo_c;

  // The pointer always equals the number of entries matched so far.
  assign ptr_c = bus.match_cnt[IDX_W-1:0];

  check_table #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_table (
    .clk   (clk),
    .we    (bus.cfg_we && (state == IDLE)),
    .widx  (bus.cfg_idx),
    .waddr (bus.cfg_addr),
    .wdata (bus.cfg_data),
    .ridx  (ptr_c),
    .raddr (exp_addr_c),
    .rdata (exp_data_c)
  );

  assign hit_c     = bus.MemWrite && (bus.DataAdr == exp_addr_c) && (bus.WriteData == exp_data_c);
  assign ign_c     = bus.MemWrite && ign_en_q && (bus.DataAdr == ign_addr_q);
  assign num_ok_c  = (bus.num_checks != '0) && (bus.num_checks <= DEPTH_V);
  assign cyc_nxt_c = cyc_cnt + ONE_T;
  assign tmo_c     = (timeout_q != '0) && (cyc_nxt_c == timeout_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      num_q            <= '0;
      ign_en_q         <= 1'b0;
      ign_addr_q       <= '0;
      timeout_q        <= '0;
      cyc_cnt          <= '0;
      bus.busy         <= 1'b0;
      bus.pass         <= 1'b0;
      bus.fail         <= 1'b0;
      bus.fail_timeout <= 1'b0;
      bus.fail_idx     <= '0;
      bus.bad_addr     <= '0;
      bus.bad_data     <= '0;
      bus.match_cnt    <= '0;
      bus.ign_cnt      <= '0;
    end else begin
      unique case (state)
        IDLE, PASS, FAIL: begin
          // Arming clears all diagnostics; a bad entry count fails immediately.
          if (bus.start) begin
            num_q            <= bus.num_checks;
            ign_en_q         <= bus.ign_en;
            ign_addr_q       <= bus.ign_addr;
            timeout_q        <= bus.timeout;
            cyc_cnt          <= '0;
            bus.pass         <= 1'b0;
            bus.fail_timeout <= 1'b0;
            bus.fail_idx     <= '0;
            bus.bad_addr     <= '0;
            bus.bad_data     <= '0;
            bus.match_cnt    <= '0;
            bus.ign_cnt      <= '0;
            if (num_ok_c) begin
              state    <= RUN;
              bus.busy <= 1'b1;
              bus.fail <= 1'b0;
            end else begin
              state    <= FAIL;
              bus.busy <= 1'b0;
              bus.fail <= 1'b1;
            end
          end
        end
        RUN: begin
          cyc_cnt <= cyc_nxt_c;
          if (hit_c) begin
            bus.match_cnt <= bus.match_cnt + ONE_M;
            if (bus.match_cnt == (num_q - ONE_M)) begin
              state    <= PASS;
              bus.busy <= 1'b0;
              bus.pass <= 1'b1;
            end
          end else if (bus.MemWrite && !ign_c) begin
            state        <= FAIL;
            bus.busy     <= 1'b0;
            bus.fail     <= 1'b1;
            bus.fail_idx <= ptr_c;
            bus.bad_addr <= bus.DataAdr;
            bus.bad_data <= bus.WriteData;
          end else begin
            // Ignored stores are not deciding, so the timeout can still fire.
            if (ign_c && (bus.ign_cnt != '1)) begin
              bus.ign_cnt <= bus.ign_cnt + ONE_I;
            end
            if (tmo_c) begin
              state            <= FAIL;
              bus.busy         <= 1'b0;
              bus.fail         <= 1'b1;
              bus.fail_timeout <= 1'b1;
              bus.fail_idx     <= ptr_c;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_check_monitor.sv
// Randomized and directed bench for store_check_monitor against a behavioural model.
module tb_store_check_monitor;

  logic clk;
  logic reset;

  store_check_monitor_if #(.ADDR_W(32), .DATA_W(32), .DEPTH(8), .TIMEOUT_W(16)) bus ();

  store_check_monitor #(.ADDR_W(32), .DATA_W(32), .DEPTH(8), .TIMEOUT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec;
  int n_err;

  // Behavioural model: what the outputs must be after each edge.
  logic [31:0] tab_a [8];
  logic [31:0] tab_d [8];
  bit          m_run;
  int          m_num;
  int          m_tmo;
  int          m_elapsed;
  bit          m_ign_en;
  logic [31:0] m_ign_addr;
  bit          e_busy, e_pass, e_fail, e_tmo;
  int          e_idx, e_match, e_ign;
  logic [31:0] e_baddr, e_bdata;

  task automatic clear_expect();
    e_busy = 0; e_pass = 0; e_fail = 0; e_tmo = 0;
    e_idx = 0; e_match = 0; e_ign = 0; e_baddr = '0; e_bdata = '0;
  endtask

  task automatic model_step();
    bit hit, ign, decided;
    if (reset) begin
      m_run = 0;
      clear_expect();
      return;
    end
    if (!m_run) begin
      if (!e_pass && !e_fail && bus.cfg_we) begin
        tab_a[bus.cfg_idx] = bus.cfg_addr;
        tab_d[bus.cfg_idx] = bus.cfg_data;
      end
      if (bus.start) begin
        clear_expect();
        m_elapsed = 0;
        if (bus.num_checks >= 1 && bus.num_checks <= 8) begin
          m_run      = 1;
          m_num      = int'(bus.num_checks);
          m_tmo      = int'(bus.timeout);
          m_ign_en   = bus.ign_en;
          m_ign_addr = bus.ign_addr;
        end else begin
          e_fail = 1;
        end
      end
    end else begin
      m_elapsed++;
      hit = bus.MemWrite && bus.DataAdr == tab_a[e_match] && bus.WriteData == tab_d[e_match];
      ign = bus.MemWrite && m_ign_en && bus.DataAdr == m_ign_addr;
      decided = hit || (bus.MemWrite && !ign);
      if (hit) begin
        e_match++;
        if (e_match == m_num) begin
          e_pass = 1;
          m_run  = 0;
        end
      end else if (bus.MemWrite && !ign) begin
        e_fail  = 1;
        e_idx   = e_match;
        e_baddr = bus.DataAdr;
        e_bdata = bus.WriteData;
        m_run   = 0;
      end else if (ign && e_ign < 65535) begin
        e_ign++;
      end
      if (!decided && m_tmo != 0 && m_elapsed == m_tmo) begin
        e_fail = 1;
        e_tmo  = 1;
        e_idx  = e_match;
        m_run  = 0;
      end
    end
    e_busy = m_run;
  endtask

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    cmp("busy",         32'(bus.busy),         32'(e_busy));
    cmp("pass",         32'(bus.pass),         32'(e_pass));
    cmp("fail",         32'(bus.fail),         32'(e_fail));
    cmp("fail_timeout", 32'(bus.fail_timeout), 32'(e_tmo));
    cmp("fail_idx",     32'(bus.fail_idx),     32'(e_idx));
    cmp("bad_addr",     bus.bad_addr,          e_baddr);
    cmp("bad_data",     bus.bad_data,          e_bdata);
    cmp("match_cnt",    32'(bus.match_cnt),    32'(e_match));
    cmp("ign_cnt",      32'(bus.ign_cnt),      32'(e_ign));
  endtask

  // One clock: model samples the same inputs as the DUT, outputs are checked on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_inputs();
    reset = 0;
    bus.MemWrite = 0; bus.DataAdr = '0; bus.WriteData = '0;
    bus.cfg_we = 0; bus.cfg_idx = '0; bus.cfg_addr = '0; bus.cfg_data = '0;
    bus.num_checks = '0; bus.ign_en = 0; bus.ign_addr = '0; bus.timeout = '0;
    bus.start = 0;
  endtask

  task automatic do_reset();
    reset = 1; tick(); reset = 0;
  endtask

  task automatic wr(input int idx, input logic [31:0] a, input logic [31:0] d);
    bus.cfg_we = 1; bus.cfg_idx = 3'(idx); bus.cfg_addr = a; bus.cfg_data = d;
    tick();
    bus.cfg_we = 0;
  endtask

  task automatic arm(input int num, input bit ien, input logic [31:0] iaddr, input int tmo);
    bus.start = 1; bus.num_checks = 4'(num); bus.ign_en = ien;
    bus.ign_addr = iaddr; bus.timeout = 16'(tmo);
    tick();
    bus.start = 0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.MemWrite = 1; bus.DataAdr = a; bus.WriteData = d;
    tick();
    bus.MemWrite = 0;
  endtask

  function automatic logic [31:0] pick_addr();
    if ($urandom_range(0, 7) == 0) return $urandom;
    return 32'h10 + 32'(4 * $urandom_range(0, 3));
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    m_run = 0;
    clear_expect();
    for (int i = 0; i < 8; i++) begin
      tab_a[i] = '0;
      tab_d[i] = '0;
    end
    idle_inputs();

    // Table contents are unknown until written; load every entry once.
    do_reset();
    for (int i = 0; i < 8; i++) wr(i, 32'hF00 + 32'(i), 32'(i));
    cmp("reset_busy", 32'(bus.busy), 32'd0);
    cmp("reset_fail", 32'(bus.fail), 32'd0);

    // Ignore address skipped, then the single entry matches.
    wr(0, 32'd100, 32'd7);
    arm(1, 1, 32'd96, 0);
    store(32'd96, 32'd11);
    store(32'd96, 32'd12);
    cmp("lit_busy_before", 32'(bus.busy), 32'd1);
    store(32'd100, 32'd7);
    cmp("lit_pass", 32'(bus.pass), 32'd1);
    cmp("lit_ign_cnt", 32'(bus.ign_cnt), 32'd2);
    cmp("lit_match_cnt", 32'(bus.match_cnt), 32'd1);

    // Re-arm from PASS; wrong data fails.
    arm(1, 1, 32'd96, 0);
    cmp("lit_rearm_pass", 32'(bus.pass), 32'd0);
    cmp("lit_rearm_ign", 32'(bus.ign_cnt), 32'd0);
    store(32'd96, 32'd1);
    store(32'd100, 32'd8);
    cmp("lit_fail", 32'(bus.fail), 32'd1);
    cmp("lit_bad_addr", bus.bad_addr, 32'd100);
    cmp("lit_bad_data", bus.bad_data, 32'd8);
    cmp("lit_fail_tmo", 32'(bus.fail_timeout), 32'd0);

    // Three in-order stores, then out-of-order.
    do_reset();
    wr(0, 32'h10, 32'd1); wr(1, 32'h14, 32'd2); wr(2, 32'h18, 32'd3);
    arm(3, 0, 32'd0, 0);
    store(32'h10, 32'd1); store(32'h14, 32'd2); store(32'h18, 32'd3);
    cmp("lit_pass3", 32'(bus.pass), 32'd1);
    cmp("lit_match3", 32'(bus.match_cnt), 32'd3);
    arm(3, 0, 32'd0, 0);
    store(32'h14, 32'd2);
    cmp("lit_ooo_fail", 32'(bus.fail), 32'd1);
    cmp("lit_ooo_idx", 32'(bus.fail_idx), 32'd0);

    // Timeout of 20 cycles with no stores.
    arm(3, 0, 32'd0, 20);
    for (int i = 0; i < 19; i++) tick();
    cmp("lit_tmo_early", 32'(bus.fail), 32'd0);
    tick();
    cmp("lit_tmo_fail", 32'(bus.fail), 32'd1);
    cmp("lit_tmo_flag", 32'(bus.fail_timeout), 32'd1);

    // Matching store on the timeout edge wins.
    arm(1, 0, 32'd0, 20);
    for (int i = 0; i < 19; i++) tick();
    store(32'h10, 32'd1);
    cmp("lit_tmo_pass", 32'(bus.pass), 32'd1);
    cmp("lit_tmo_nofail", 32'(bus.fail), 32'd0);

    // Reset mid-run, then cfg_we during RUN must not alter the table.
    arm(3, 0, 32'd0, 0);
    store(32'h10, 32'd1);
    cmp("lit_mid_match", 32'(bus.match_cnt), 32'd1);
    do_reset();
    cmp("lit_rst_match", 32'(bus.match_cnt), 32'd0);
    cmp("lit_rst_busy", 32'(bus.busy), 32'd0);
    arm(3, 0, 32'd0, 0);
    wr(1, 32'h99, 32'h99);
    store(32'h10, 32'd1); store(32'h14, 32'd2); store(32'h18, 32'd3);
    cmp("lit_cfg_ignored", 32'(bus.pass), 32'd1);

    // Re-arm from PASS with fewer checks, then invalid counts.
    arm(2, 0, 32'd0, 0);
    store(32'h10, 32'd1); store(32'h14, 32'd2);
    cmp("lit_pass2", 32'(bus.match_cnt), 32'd2);
    arm(0, 0, 32'd0, 0);
    cmp("lit_zero_fail", 32'(bus.fail), 32'd1);
    cmp("lit_zero_idx", 32'(bus.fail_idx), 32'd0);
    arm(9, 0, 32'd0, 0);
    cmp("lit_big_fail", 32'(bus.fail), 32'd1);

    // Randomized traffic checked every cycle by the model.
    for (int c = 0; c < 3000; c++) begin
      reset          = ($urandom_range(0, 299) == 0);
      bus.start      = ($urandom_range(0, 19) == 0);
      bus.num_checks = 4'($urandom_range(0, 9));
      bus.ign_en     = 1'($urandom_range(0, 1));
      bus.ign_addr   = pick_addr();
      bus.timeout    = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(3, 30));
      bus.cfg_we     = 1'($urandom_range(0, 1));
      bus.cfg_idx    = 3'($urandom_range(0, 7));
      bus.cfg_addr   = pick_addr();
      bus.cfg_data   = 32'($urandom_range(0, 3));
      bus.MemWrite   = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 7))
        0, 1, 2, 3, 4: begin
          bus.DataAdr   = tab_a[e_match % 8];
          bus.WriteData = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 3)) : tab_d[e_match % 8];
        end
        5: begin
          bus.DataAdr   = m_ign_addr;
          bus.WriteData = 32'($urandom_range(0, 3));
        end
        default: begin
          bus.DataAdr   = pick_addr();
          bus.WriteData = 32'($urandom_range(0, 3));
        end
      endcase
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
